// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI-slave (mode 0, write-only) configuration controller owning the
// five output-enable / PWM registers. All SPI pins are synchronised into clk.
`default_nettype none

module spi_reg_ctrl #(
    parameter int MAX_ADDR   = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int               CNT_W      = 5;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(FRAME_BITS + 1);
    localparam logic [6:0]       MAX_ADDR_V = 7'(MAX_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic sclk_meta, sclk_sync, sclk_last;
    logic copi_meta, copi_sync, copi_last;
    logic ncs_meta,  ncs_sync,  ncs_last;

    logic                  sclk_rise;
    logic                  ncs_rise;
    logic                  shift_en;
    logic                  cnt_clr;
    logic                  commit;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_reg;

    logic       frame_rw;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_ok;
    logic       addr_ok;
    logic       do_write;

    // Two metastability flops plus one history flop per pin for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_last <= 1'b0;
            copi_meta <= 1'b0;
            copi_sync <= 1'b0;
            copi_last <= 1'b0;
            ncs_meta  <= 1'b1;
            ncs_sync  <= 1'b1;
            ncs_last  <= 1'b1;
        end else begin
            sclk_meta <= sclk_i;
            sclk_sync <= sclk_meta;
            sclk_last <= sclk_sync;
            copi_meta <= copi_i;
            copi_sync <= copi_meta;
            copi_last <= copi_sync;
            ncs_meta  <= ncs_i;
            ncs_sync  <= ncs_meta;
            ncs_last  <= ncs_sync;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_last;
    assign ncs_rise  = ncs_sync  & ~ncs_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (!ncs_sync) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = sclk_rise;
                if (ncs_rise) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit = 1'b1;
                // A new frame may already have started during the commit cycle.
                if (!ncs_sync) begin
                    state_nxt = ST_SHIFT;
                    cnt_clr   = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en && (bit_cnt != CNT_SAT)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_last};
            end
        end
    end

    assign frame_rw   = shift_reg[FRAME_BITS-1];
    assign frame_addr = shift_reg[FRAME_BITS-2 -: 7];
    assign frame_data = shift_reg[7:0];
    assign frame_ok   = (bit_cnt == CNT_FULL);
    assign addr_ok    = (frame_addr <= MAX_ADDR_V);
    assign do_write   = commit & frame_ok & frame_rw & addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            frame_done      <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            frame_done <= commit & frame_ok;
            frame_err  <= commit & ~frame_ok;
            if (do_write) begin
                case (frame_addr)
                    7'd0:    en_reg_out_7_0  <= frame_data;
                    7'd1:    en_reg_out_15_8 <= frame_data;
                    7'd2:    en_reg_pwm_7_0  <= frame_data;
                    7'd3:    en_reg_pwm_15_8 <= frame_data;
                    7'd4:    pwm_duty_cycle  <= frame_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
